// File: rtl/decode_issue.sv
// Decode/issue stage feeding execute; sole owner of the 8x16 register file ports.
// Optional DECODE_STALL_CNT_EN adds a saturating stall counter output.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   instr_valid/instr/instr_ready   instruction handshake
//   rf_addr_op1/op2, rf_out_op1/op2 registered read port of the register file
//   rf_load/rf_addr/rf_data         register file write port (copy of wb_*)
//   wb_valid/wb_addr/wb_data        writeback from execute, always accepted
//   ex_valid/ex_ready               issue handshake to execute
//   ex_opcode/ex_rd/ex_a/ex_b       issued operation
//   stall_cnt                       (DECODE_STALL_CNT_EN only) stall cycles
module decode_issue #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] rf_addr_op1,
    output logic [ADDR_W-1:0] rf_addr_op2,
    input  logic [DATA_W-1:0] rf_out_op1,
    input  logic [DATA_W-1:0] rf_out_op2,
    output logic              rf_load,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [3:0]        ex_opcode,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [3:0] OP_NOP = 4'hF;
    localparam logic [3:0] OP_LDI = 4'hE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HAZ,
        S_READ,
        S_ISSUE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;

    logic [3:0]        ir_op;
    logic [ADDR_W-1:0] ir_rd;
    logic [ADDR_W-1:0] ir_rs1;
    logic [ADDR_W-1:0] ir_rs2;
    logic              ir_ldi;
    logic              haz;

    assign ir_op  = ir_q[15:12];
    assign ir_rd  = ir_q[11:9];
    assign ir_rs1 = ir_q[8:6];
    assign ir_rs2 = ir_q[5:3];
    assign ir_ldi = (ir_op == OP_LDI);

    // An active writeback owns the write port, so the stage waits it out
    // even when no operand is involved.
    assign haz = busy_q[ir_rd]
               | (~ir_ldi & (busy_q[ir_rs1] | busy_q[ir_rs2]))
               | wb_valid;

    assign rf_addr_op1 = ir_rs1;
    assign rf_addr_op2 = ir_rs2;
    assign rf_load     = wb_valid;
    assign rf_addr     = wb_addr;
    assign rf_data     = wb_data;

    assign ex_opcode = ir_op;
    assign ex_rd     = ir_rd;
    assign ex_a      = ex_a_q;
    assign ex_b      = ex_b_q;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        busy_d      = busy_q;
        ex_a_d      = ex_a_q;
        ex_b_d      = ex_b_q;
        instr_ready = 1'b0;
        ex_valid    = 1'b0;

        if (wb_valid) begin
            busy_d[wb_addr] = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid && instr[15:12] != OP_NOP) begin
                    ir_d    = instr;
                    state_d = S_HAZ;
                end
            end
            S_HAZ: begin
                if (!haz) begin
                    if (ir_ldi) begin
                        ex_a_d  = DATA_W'(ir_q[5:0]);
                        ex_b_d  = '0;
                        state_d = S_ISSUE;
                    end else begin
                        // Register file samples rf_addr_op* at this edge.
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                ex_a_d  = rf_out_op1;
                ex_b_d  = rf_out_op2;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                ex_valid = 1'b1;
                if (ex_ready) begin
                    // rd was non-busy in HAZ, so no clear can collide here.
                    busy_d[ir_rd] = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            busy_q  <= '0;
            ex_a_q  <= '0;
            ex_b_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            busy_q  <= busy_d;
            ex_a_q  <= ex_a_d;
            ex_b_q  <= ex_b_d;
        end
    end

`ifdef DECODE_STALL_CNT_EN
    logic        stall;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall = ((state_q == S_HAZ) & haz)
                 | ((state_q == S_ISSUE) & ~ex_ready);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_issue.sv
// Testbench for decode_issue: register file model, directed scenarios,
// then randomized traffic against a transaction-level scoreboard.
module tb_decode_issue;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  rf_addr_op1;
    logic [2:0]  rf_addr_op2;
    logic [15:0] rf_out_op1;
    logic [15:0] rf_out_op2;
    logic        rf_load;
    logic [2:0]  rf_addr;
    logic [15:0] rf_data;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_opcode;
    logic [2:0]  ex_rd;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_base;
`endif

    decode_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .rf_addr_op1(rf_addr_op1),
        .rf_addr_op2(rf_addr_op2),
        .rf_out_op1 (rf_out_op1),
        .rf_out_op2 (rf_out_op2),
        .rf_load    (rf_load),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_opcode  (ex_opcode),
        .ex_rd      (ex_rd),
        .ex_a       (ex_a),
        .ex_b       (ex_b)
`ifdef DECODE_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8x16 register file with a registered read port that only updates
    // on edges without a write.
    logic [15:0] mem [8];
    always @(posedge clk) begin
        if (rf_load) begin
            mem[rf_addr] <= rf_data;
        end else begin
            rf_out_op1 <= mem[rf_addr_op1];
            rf_out_op2 <= mem[rf_addr_op2];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Architectural register contents as the bench believes them.
    logic [15:0] arch [8];

    task automatic wb_drive(input logic v, input logic [2:0] a,
                            input logic [15:0] d);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
        if (v) arch[a] = d;
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op,
                                       input logic [2:0] rd,
                                       input logic [2:0] rs1,
                                       input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] mk_ldi(input logic [2:0] rd,
                                           input logic [5:0] imm);
        return {4'hE, rd, 3'b000, imm};
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        ex_ready    = 1'b0;
        wb_drive(1'b0, 3'd0, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_issue(input string tag, input logic [3:0] op,
                             input logic [2:0] rd, input logic [15:0] a,
                             input logic [15:0] b);
        check({tag, "_valid"}, 32'(ex_valid), 32'd1);
        check({tag, "_op"}, 32'(ex_opcode), 32'(op));
        check({tag, "_rd"}, 32'(ex_rd), 32'(rd));
        check({tag, "_a"}, 32'(ex_a), 32'(a));
        check({tag, "_b"}, 32'(ex_b), 32'(b));
    endtask

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        int          due;
    } wbe_t;

    wbe_t        wq[$];
    bit          pend [8];
    bit          infl;
    int          m_due;
    logic [3:0]  m_op;
    logic [2:0]  m_rd, m_rs1, m_rs2;
    logic [5:0]  m_imm;
    int          stalls;

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        ex_ready    = 1'b0;
        wb_drive(1'b0, 3'd0, 16'd0);
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_op", 32'(ex_opcode), 32'd0);
        check("rst_rd", 32'(ex_rd), 32'd0);
        check("rst_a", 32'(ex_a), 32'd0);
        check("rst_b", 32'(ex_b), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(instr_ready), 32'd1);
`ifdef DECODE_STALL_CNT_EN
        check("rst_stall", 32'(stall_cnt), 32'd0);
`endif

        // Preload every register through the write port.
        for (int i = 0; i < 8; i++) begin
            wb_drive(1'b1, 3'(i),
                     (i == 0) ? 16'd10 : (i == 1) ? 16'd1000 : 16'(100 + i));
            #1;
            check("pre_load", 32'(rf_load), 32'd1);
            check("pre_addr", 32'(rf_addr), 32'(i));
            check("pre_data", 32'(rf_data), 32'(arch[i]));
            @(negedge clk);
        end
        wb_drive(1'b0, 3'd0, 16'd0);

        // ADD r2 <- r0, r1
        ex_ready    = 1'b1;
        instr       = mk(4'h0, 3'd2, 3'd0, 3'd1);
        instr_valid = 1'b1;
        check("add_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        check("add_c1_valid", 32'(ex_valid), 32'd0);
        check("add_c1_ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        check("add_c2_valid", 32'(ex_valid), 32'd0);
        @(negedge clk);
        chk_issue("add", 4'h0, 3'd2, 16'd10, 16'd1000);
        @(negedge clk);
        check("add_done", 32'(ex_valid), 32'd0);
        check("add_done_ready", 32'(instr_ready), 32'd1);

        // SUB r3 <- r2, r1 waits for r2's writeback
        instr       = mk(4'h1, 3'd3, 3'd2, 3'd1);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("sub_stall", 32'(ex_valid), 32'd0);
            check("sub_stall_ready", 32'(instr_ready), 32'd0);
            @(negedge clk);
        end
        wb_drive(1'b1, 3'd2, 16'd1010);
        check("sub_wb_cyc", 32'(ex_valid), 32'd0);
        @(negedge clk);
        wb_drive(1'b0, 3'd0, 16'd0);
        check("sub_wb1", 32'(ex_valid), 32'd0);
        @(negedge clk);
        check("sub_wb2", 32'(ex_valid), 32'd0);
        @(negedge clk);
        chk_issue("sub", 4'h1, 3'd3, 16'd1010, 16'd1000);
        @(negedge clk);

        // LDI r5, #37 held 5 cycles by execute
`ifdef DECODE_STALL_CNT_EN
        stall_base = stall_cnt;
`endif
        ex_ready    = 1'b0;
        instr       = mk_ldi(3'd5, 6'd37);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("ldi_c1_valid", 32'(ex_valid), 32'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk_issue("ldi_hold", 4'hE, 3'd5, 16'd37, 16'd0);
            check("ldi_hold_ready", 32'(instr_ready), 32'd0);
            @(negedge clk);
        end
        chk_issue("ldi_rel", 4'hE, 3'd5, 16'd37, 16'd0);
`ifdef DECODE_STALL_CNT_EN
        check("ldi_stall_cnt", 32'(stall_cnt - stall_base), 32'd5);
`endif
        ex_ready = 1'b1;
        @(negedge clk);
        check("ldi_done", 32'(ex_valid), 32'd0);

        // AND r6 <- r0, r1 with writeback busy for 3 cycles
        instr       = mk(4'h2, 3'd6, 3'd0, 3'd1);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        wb_drive(1'b1, 3'd3, 16'h0333);
        #1;
        check("wbh_load1", 32'(rf_load), 32'd1);
        check("wbh_v1", 32'(ex_valid), 32'd0);
        @(negedge clk);
        wb_drive(1'b1, 3'd5, 16'h0555);
        #1;
        check("wbh_load2", 32'(rf_load), 32'd1);
        @(negedge clk);
        wb_drive(1'b1, 3'd7, 16'd77);
        #1;
        check("wbh_load3", 32'(rf_load), 32'd1);
        @(negedge clk);
        wb_drive(1'b0, 3'd0, 16'd0);
        check("wbh_v4", 32'(ex_valid), 32'd0);
        @(negedge clk);
        check("wbh_v5", 32'(ex_valid), 32'd0);
        @(negedge clk);
        chk_issue("wbh", 4'h2, 3'd6, 16'd10, 16'd1000);
        @(negedge clk);

        // rd == rs1 == rs2 on a register written while non-busy
        instr       = mk(4'h3, 3'd7, 3'd7, 3'd7);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_issue("same", 4'h3, 3'd7, 16'd77, 16'd77);
        @(negedge clk);

        // NOP
        instr       = 16'hFABC;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("nop_ready", 32'(instr_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("nop_valid", 32'(ex_valid), 32'd0);
            @(negedge clk);
        end

        // Reset while in READ
        instr       = mk(4'h4, 3'd1, 3'd0, 3'd0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rrd_valid", 32'(ex_valid), 32'd0);
        check("rrd_ready", 32'(instr_ready), 32'd1);
        check("rrd_a", 32'(ex_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // r6 and r7 were left busy; reset must have cleared them.
        instr       = mk(4'h5, 3'd4, 3'd6, 3'd7);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_issue("post_rst", 4'h5, 3'd4, 16'd106, 16'd77);
        @(negedge clk);

        // Randomized traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 8; i++) pend[i] = 1'b0;
        infl   = 1'b0;
        m_due  = 0;
        stalls = 0;
        wq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit idle;
            bit ev;
            bit ldi;
            int r;
            idle = !infl;
            ev   = infl && m_due != 0 && cyc >= m_due;
            check("r_ready", 32'(instr_ready), 32'(idle));
            check("r_valid", 32'(ex_valid), 32'(ev));
            if (ev) begin
                if (m_op == 4'hE)
                    chk_issue("r_iss", m_op, m_rd, {10'd0, m_imm}, 16'd0);
                else
                    chk_issue("r_iss", m_op, m_rd, arch[m_rs1], arch[m_rs2]);
            end
`ifdef DECODE_STALL_CNT_EN
            check("r_stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
            if (wq.size() > 0 && wq[0].due <= cyc && $urandom_range(3) != 0)
                wb_drive(1'b1, wq[0].a, wq[0].d);
            else
                wb_drive(1'b0, 3'($urandom), 16'($urandom));
            ex_ready    = ($urandom_range(2) != 0);
            instr_valid = 1'($urandom_range(1));
            r = $urandom_range(9);
            instr = 16'($urandom);
            if (r == 0) instr[15:12] = 4'hF;
            else if (r < 3) instr[15:12] = 4'hE;
            else instr[15:12] = 4'($urandom_range(13));
            #1;
            check("r_rf_load", 32'(rf_load), 32'(wb_valid));
            if (wb_valid) begin
                check("r_rf_addr", 32'(rf_addr), 32'(wb_addr));
                check("r_rf_data", 32'(rf_data), 32'(wb_data));
            end

            if (infl && m_due == 0) begin
                ldi = (m_op == 4'hE);
                if (!pend[m_rd] && (ldi || (!pend[m_rs1] && !pend[m_rs2]))
                    && !wb_valid)
                    m_due = cyc + (ldi ? 1 : 2);
                else
                    stalls++;
            end else if (ev) begin
                if (ex_ready) begin
                    pend[m_rd] = 1'b1;
                    wq.push_back('{a: m_rd, d: 16'($urandom),
                                   due: cyc + 1 + $urandom_range(4)});
                    infl = 1'b0;
                end else begin
                    stalls++;
                end
            end
            if (wb_valid) begin
                pend[wb_addr] = 1'b0;
                void'(wq.pop_front());
            end
            if (idle && instr_valid && instr[15:12] != 4'hF) begin
                infl  = 1'b1;
                m_due = 0;
                m_op  = instr[15:12];
                m_rd  = instr[11:9];
                m_rs1 = instr[8:6];
                m_rs2 = instr[5:3];
                m_imm = instr[5:0];
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
